// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end and IF/ID pipeline register.
// Owns the PC, drives a variable-latency req/ack instruction memory and
// raises fetchStall while a request is pending so the pipeline freezes.
// Optional build macro FETCH_PERF_EN adds stall/fetch performance counters;
// without it perfStall and perfFetch are tied to zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset, no request, ack ignored
// REQ   | request pc (or flag a misaligned fetch without a request)
// HOLD  | word captured while PC was frozen; serve it until PC moves
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PC_Write,
    input  logic        IF_Write,
    input  logic        IF_Flush,
    input  logic [1:0]  addrSel,
    input  logic [31:0] jumpAddr,
    input  logic [31:0] branchAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetchStall,
    output logic [31:0] instrID,
    output logic [31:0] pcPlus4ID,
    output logic        validID,
    output logic        excID,
    output logic [31:0] perfStall,
    output logic [31:0] perfFetch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_id_q;
    logic        valid_q;
    logic        exc_q;

    logic        is_req;
    logic        is_hold;
    logic        mis;
    logic        have;
    logic        stall;
    logic [31:0] data;
    logic [31:0] pc_plus4;
    logic [31:0] npc_d;
    logic        if_load_valid;

    assign is_req   = (state_q == REQ);
    assign is_hold  = (state_q == HOLD);
    assign mis      = (pc_q[1:0] != 2'b00);
    assign have     = (is_req && (imem_ack || mis)) || is_hold;
    assign stall    = is_req && !imem_ack && !mis;
    assign data     = is_hold ? hold_q : (mis ? 32'h0 : imem_rdata);
    assign pc_plus4 = pc_q + 32'd4;

    // A fresh IF/ID entry is written this cycle (flush has priority)
    assign if_load_valid = !stall && !IF_Flush && IF_Write && have;

    assign imem_req   = is_req && !mis;
    assign imem_addr  = pc_q;
    assign fetchStall = stall;
    assign instrID    = instr_q;
    assign pcPlus4ID  = pc4_id_q;
    assign validID    = valid_q;
    assign excID      = exc_q;

    // Next-PC selection
    always_comb begin
        npc_d = pc_plus4;
        case (addrSel)
            2'b00:   npc_d = pc_plus4;
            2'b01:   npc_d = jumpAddr;
            2'b10:   npc_d = branchAddr;
            default: npc_d = EXC_VECTOR;
        endcase
    end

    // Fetch FSM and capture of a word returned while the PC is frozen
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            hold_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    // A misaligned pc never issues a request, so any ack is stray
                    if (!mis && imem_ack && !PC_Write) begin
                        hold_q  <= imem_rdata;
                        state_q <= HOLD;
                    end else begin
                        state_q <= REQ;
                    end
                end
                HOLD: begin
                    if (PC_Write) begin
                        state_q <= REQ;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // PC register, frozen while memory is pending
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc_q <= RESET_PC;
        end else if (!stall && PC_Write) begin
            pc_q <= npc_d;
        end
    end

    // IF/ID pipeline register: flush beats load, both frozen on stall
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            instr_q  <= 32'h0;
            pc4_id_q <= 32'h0;
            valid_q  <= 1'b0;
            exc_q    <= 1'b0;
        end else if (!stall) begin
            if (IF_Flush) begin
                instr_q <= 32'h0;
                valid_q <= 1'b0;
                exc_q   <= 1'b0;
            end else if (IF_Write && have) begin
                instr_q  <= data;
                pc4_id_q <= pc_plus4;
                valid_q  <= 1'b1;
                exc_q    <= mis;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_fetch_q;

    // Stall-cycle and delivered-instruction counters, wrapping
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            perf_stall_q <= 32'h0;
            perf_fetch_q <= 32'h0;
        end else begin
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (if_load_valid) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
        end
    end

    assign perfStall = perf_stall_q;
    assign perfFetch = perf_fetch_q;
`else
    assign perfStall = 32'h0;
    assign perfFetch = 32'h0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end and IF/ID pipeline register. It consumes the hazard unit's control outputs (PC_Write, IF_Write, IF_Flush, addrSel) and owns the PC register. It drives a variable-latency instruction-memory req/ack interface and returns fetchStall, which the top level uses to freeze the hazard unit and the downstream pipeline.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0180, target selected by addrSel=2'b11.

Ports:
Clk  in  1  clock; all state updates on posedge.
Rst  in  1  asynchronous, active-low reset.
PC_Write  in  1  PC load enable from hazard unit.
IF_Write  in  1  IF/ID load enable.
IF_Flush  in  1  clear IF/ID to a NOP bubble.
addrSel  in  2  next-PC select: 00 pc+4, 01 jumpAddr, 10 branchAddr, 11 EXC_VECTOR.
jumpAddr  in  32  jump / jr target.
branchAddr  in  32  branch target.
imem_req  out  1  fetch request; held with a stable address until ack.
imem_addr  out  32  fetch address (= pc).
imem_ack  in  1  response valid this cycle; same-cycle ack (zero wait) is allowed.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
fetchStall  out  1  memory pending; the pipeline must freeze.
instrID  out  32  IF/ID instruction.
pcPlus4ID  out  32  IF/ID pc+4.
validID  out  1  IF/ID holds a real instruction.
excID  out  1  IF/ID instruction raised a misaligned-fetch exception.
perfStall  out  32  stall-cycle counter (see optional feature).
perfFetch  out  32  delivered-instruction counter (see optional feature).

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE, pc=RESET_PC, imem_req=0, instrID=0, pcPlus4ID=0, validID=0, excID=0, holdInstr=0, counters=0.
- Misaligned fetch: mis = (pc[1:0]!=0). have = (REQ && (imem_ack || mis)) || HOLD. data = HOLD ? holdInstr : (mis ? 0 : imem_rdata).
- fetchStall = REQ && !imem_ack && !mis. It is combinational and is 0 in IDLE and HOLD.
- imem_req = REQ && !mis. imem_addr = pc at all times.
- While fetchStall=1: PC_Write, IF_Write and IF_Flush are ignored; pc, IF/ID and state hold; imem_addr stays stable.
- PC update, when !fetchStall && PC_Write: pc <= npc per addrSel. pc+4 wraps modulo 2^32.
- IF/ID update, when !fetchStall, evaluated in priority order:
  1. IF_Flush: validID=0, instrID=0, excID=0. Flush beats IF_Write.
  2. IF_Write && have: instrID=data, pcPlus4ID=pc+4, validID=1, excID=mis.
  3. Otherwise IF/ID holds.
- FSM:
  - IDLE: one cycle, no request, imem_ack ignored -> REQ.
  - REQ, imem_ack=1 and PC_Write=1: stay in REQ; the new pc is requested next cycle.
  - REQ, imem_ack=1 and PC_Write=0: capture holdInstr=imem_rdata -> HOLD. The word is delivered to IF/ID this cycle as well if IF_Write=1.
  - REQ, imem_ack=0 and !mis: stay in REQ (stall).
  - REQ, mis: stay in REQ with no request issued; pc moves on PC_Write.
  - HOLD: no request, holdInstr is the data source; PC_Write=1 -> REQ (holdInstr discarded, including on redirect); else stay in HOLD. The same address is never refetched.
- The memory must tolerate a request abandoned by reset. Any ack arriving in IDLE is ignored.

Optional Feature:
FETCH_PERF_EN.
- Defined: perfStall increments every cycle fetchStall=1. perfFetch increments on every IF/ID load with validID<=1. Both wrap at 2^32 and clear on reset.
- Undefined: no counter registers; perfStall and perfFetch are tied to 0. The port list is unchanged.

Test Plan:
1. Hold Rst=0, then release -> during reset imem_req=0, validID=0, instrID=0. First cycle after release: imem_req=0. Second cycle: imem_req=1, imem_addr=0x0.
2. Zero-wait stream (ack=1 every cycle; PC_Write=IF_Write=1; addrSel=00) -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles. instrID equals the word fetched at 0x0 one cycle later, with pcPlus4ID=0x4, validID=1, fetchStall=0 throughout.
3. ack=0 for 3 cycles at addr 0x8, then ack=1 with 0x8C410000 -> fetchStall=1 for exactly 3 cycles, addr stays 0x8, IF/ID holds. On the ack cycle instrID<=0x8C410000 and pcPlus4ID<=0xC.
4. Load-use stall: PC_Write=IF_Write=0 while ack=1 at 0xC with data 0x00851020 -> next cycle HOLD and imem_req=0. Release with PC_Write=IF_Write=1 -> instrID=0x00851020, next request addr 0x10, no refetch of 0xC.
5. Taken branch: PC_Write=1, IF_Write=0, IF_Flush=1, addrSel=10, branchAddr=0x40 -> validID=0, instrID=0, next imem_addr=0x40.
6. Jump to jumpAddr=0x42 -> imem_req=0, no stall, IF/ID gets validID=1, excID=1, instrID=0. Then addrSel=11 with PC_Write=1 -> imem_addr=0x180, and FETCH_PERF_EN counters show the exact stall and fetch counts.
